// File: rtl/image_frame_store.sv
// rtl/image_frame_store.sv - 64x64 RGB frame buffer: raster load, in-place core access, raster dump
//
// Purpose:
//   Frame buffer owned by the image processing core. A frame is loaded as a
//   raster pixel stream, read/written in place by the core via row/col while
//   the core runs, then streamed back out in raster order once the core's
//   final stage reports done.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_pix/s_ready    load stream (raster order), accepted in LOAD
//   row/col                  core pixel address
//   in_pix                   combinational read of buffer[{row,col}]
//   out_we/out_pix           core write of buffer[{row,col}], honoured in RUN
//   done_in                  core done, moves RUN -> DUMP
//   run                      high while the core owns the buffer
//   m_valid/m_pix/m_last/m_ready  dump stream (raster order), m_last on final pixel
//   phase                    0 = LOAD, 1 = RUN, 2 = DUMP

module image_frame_store #(
    parameter int ADDR_W = 6,
    parameter int PIX_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [PIX_W-1:0]  s_pix,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] row,
    input  logic [ADDR_W-1:0] col,
    output logic [PIX_W-1:0]  in_pix,
    input  logic              out_we,
    input  logic [PIX_W-1:0]  out_pix,
    input  logic              done_in,
    output logic              run,
    output logic              m_valid,
    output logic [PIX_W-1:0]  m_pix,
    output logic              m_last,
    input  logic              m_ready,
    output logic [1:0]        phase
);

    localparam int AW    = 2 * ADDR_W;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    typedef enum logic [1:0] {
        PH_LOAD = 2'd0,
        PH_RUN  = 2'd1,
        PH_DUMP = 2'd2,
        PH_BAD  = 2'd3
    } phase_t;

    phase_t            r_phase;
    phase_t            w_phase_next;
    logic [AW-1:0]     r_load_cnt;
    logic [AW-1:0]     r_dump_cnt;
    logic [PIX_W-1:0]  r_mem [DEPTH];
    logic              r_m_valid;
    logic              r_m_last;
    logic [PIX_W-1:0]  r_m_pix;

    logic              w_load_hs;
    logic              w_core_we;
    logic              w_prefetch;
    logic              w_dump_hs;
    logic              w_fetch;
    logic [AW-1:0]     w_core_addr;

    assign w_core_addr = {row, col};
    assign s_ready     = (r_phase == PH_LOAD) & ~rst;
    assign w_load_hs   = s_valid & s_ready;
    assign w_core_we   = (r_phase == PH_RUN) & out_we & ~rst;
    // First DUMP cycle has nothing presented yet: use it to fetch pixel 0.
    assign w_prefetch  = (r_phase == PH_DUMP) & ~r_m_valid;
    assign w_dump_hs   = (r_phase == PH_DUMP) & r_m_valid & m_ready;
    // Fetch the next pixel at the same edge that consumes the current one.
    assign w_fetch     = w_prefetch | (w_dump_hs & ~r_m_last);

    assign in_pix  = r_mem[w_core_addr];
    assign run     = (r_phase == PH_RUN);
    assign m_valid = r_m_valid;
    assign m_pix   = r_m_pix;
    assign m_last  = r_m_last;
    assign phase   = r_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_LOAD;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    always_comb begin
        w_phase_next = r_phase;
        case (r_phase)
            PH_LOAD: if (w_load_hs && (r_load_cnt == LAST_ADDR)) w_phase_next = PH_RUN;
            PH_RUN:  if (done_in) w_phase_next = PH_DUMP;
            PH_DUMP: if (w_dump_hs && r_m_last) w_phase_next = PH_LOAD;
            default: w_phase_next = PH_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_cnt <= '0;
            r_dump_cnt <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_m_pix    <= '0;
        end else begin
            if (w_load_hs) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end
            if (w_fetch) begin
                r_m_pix    <= r_mem[r_dump_cnt];
                r_m_last   <= (r_dump_cnt == LAST_ADDR);
                r_m_valid  <= 1'b1;
                r_dump_cnt <= r_dump_cnt + 1'b1;
            end else if (w_dump_hs) begin
                r_m_valid  <= 1'b0;
                r_m_last   <= 1'b0;
                r_dump_cnt <= '0;
            end
        end
    end

    // Buffer has no reset: contents survive reset and phase changes.
    always_ff @(posedge clk) begin
        if (w_load_hs) begin
            r_mem[r_load_cnt] <= s_pix;
        end else if (w_core_we) begin
            r_mem[w_core_addr] <= out_pix;
        end
    end

endmodule

// File: tb/tb_image_frame_store.sv
// tb/tb_image_frame_store.sv - self-checking bench for image_frame_store
module tb_image_frame_store;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [23:0] s_pix;
    logic        s_ready;
    logic [5:0]  row;
    logic [5:0]  col;
    logic [23:0] in_pix;
    logic        out_we;
    logic [23:0] out_pix;
    logic        done_in;
    logic        run;
    logic        m_valid;
    logic [23:0] m_pix;
    logic        m_last;
    logic        m_ready;
    logic [1:0]  phase;

    int total = 0;
    int bad   = 0;

    logic [23:0] ref_mem [4096];

    image_frame_store #(.ADDR_W(6), .PIX_W(24)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_pix(s_pix), .s_ready(s_ready),
        .row(row), .col(col), .in_pix(in_pix),
        .out_we(out_we), .out_pix(out_pix), .done_in(done_in),
        .run(run),
        .m_valid(m_valid), .m_pix(m_pix), .m_last(m_last), .m_ready(m_ready),
        .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pattern_pix(input int kind, input int idx);
        logic [11:0] a;
        a = 12'(idx);
        if (kind == 0) return 24'(idx);
        return {2'b00, a[11:6], 2'b00, a[5:0], 8'hA5};
    endfunction

    // Full-frame load with random gaps; stray done_in and out_we to [3,4]
    // are driven while loading and must have no effect.
    task automatic do_load(input int kind);
        int hs  = 0;
        int cyc = 0;
        bit take;
        while (hs < 4096 && cyc < 20000) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_pix   = pattern_pix(kind, hs);
            done_in = $urandom_range(0, 1);
            out_we  = (!s_valid && hs > 300);
            row = 6'd3; col = 6'd4; out_pix = 24'hDEAD01;
            take = s_valid && s_ready;
            if (take) ref_mem[hs] = s_pix;
            step();
            cyc++;
            if (take) hs++;
            if (hs >= 4095) check("load_run", 32'(run), 32'(hs == 4096));
        end
        s_valid = 1'b0; done_in = 1'b0; out_we = 1'b0;
        check("load_count", 32'(hs), 32'd4096);
        check("load_phase", 32'(phase), 32'd1);
    endtask

    task automatic start_dump();
        done_in = 1'b1;
        m_ready = 1'b0;
        step();
        done_in = 1'b0;
        check("done_run_low", 32'(run), 32'd0);
        check("done_phase", 32'(phase), 32'd2);
        check("prefetch_valid", 32'(m_valid), 32'd0);
        step();
        check("dump_valid_rise", 32'(m_valid), 32'd1);
    endtask

    // Dump with either constant or random m_ready; stray inputs during the
    // early part of the dump must not touch the buffer or the phase.
    task automatic do_dump(input bit rand_ready);
        int idx = 0;
        int cyc = 0;
        bit hs;
        bit stalled = 1'b0;
        logic [23:0] held_pix = '0;
        logic        held_last = 1'b0;
        while (idx < 4096 && cyc < 30000) begin
            if (m_valid) begin
                check("dump_pix", 32'(m_pix), 32'(ref_mem[idx]));
                check("dump_last", 32'(m_last), 32'(idx == 4095));
                if (stalled) begin
                    check("stall_pix", 32'(m_pix), 32'(held_pix));
                    check("stall_last", 32'(m_last), 32'(held_last));
                end
            end else begin
                check("dump_gap", 32'(m_valid), 32'd1);
            end
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid = (idx < 4000); s_pix = 24'hBAD000;
            done_in = (idx < 4000);
            out_we  = (idx < 4000); row = 6'd63; col = 6'd62; out_pix = 24'hBAD111;
            hs = m_valid && m_ready;
            stalled = m_valid && !m_ready;
            held_pix = m_pix;
            held_last = m_last;
            step();
            cyc++;
            if (hs) idx++;
            if (idx < 4096) check("dump_phase", 32'(phase), 32'd2);
        end
        m_ready = 1'b0; s_valid = 1'b0; done_in = 1'b0; out_we = 1'b0;
        check("dump_count", 32'(idx), 32'd4096);
        check("dump_end_valid", 32'(m_valid), 32'd0);
        check("dump_end_phase", 32'(phase), 32'd0);
        check("dump_end_ready", 32'(s_ready), 32'd1);
    endtask

    initial begin
        int a;
        logic [23:0] v;
        rst = 1'b1; s_valid = 1'b0; s_pix = '0; row = '0; col = '0;
        out_we = 1'b0; out_pix = '0; done_in = 1'b0; m_ready = 1'b0;

        // Reset state
        step();
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_run", 32'(run), 32'd0);
        check("rst_mvalid", 32'(m_valid), 32'd0);
        check("rst_mlast", 32'(m_last), 32'd0);
        check("rst_mpix", 32'(m_pix), 32'd0);
        check("rst_sready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_sready", 32'(s_ready), 32'd1);

        // Partial load of 100 pixels then reset mid-load
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1; s_pix = 24'($urandom);
            step();
        end
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_sready", 32'(s_ready), 32'd0);
        step();
        check("midrst_phase", 32'(phase), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_sready_back", 32'(s_ready), 32'd1);

        // Full load (value = index), load counter must have restarted at 0
        do_load(0);
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(0, 4095);
            row = 6'(a >> 6); col = 6'(a & 63);
            #1;
            check("run_read", 32'(in_pix), 32'(ref_mem[a]));
        end
        row = 6'd3; col = 6'd4;
        #1;
        check("load_we_ignored", 32'(in_pix), 32'(ref_mem[3*64+4]));

        // Stray s_valid in RUN: phase holds, pixel 0 untouched
        s_valid = 1'b1; s_pix = 24'hBAD222;
        for (int i = 0; i < 5; i++) step();
        s_valid = 1'b0;
        row = 6'd0; col = 6'd0;
        #1;
        check("run_svalid_phase", 32'(phase), 32'd1);
        check("run_svalid_pix", 32'(in_pix), 32'(ref_mem[0]));

        // Dump with random backpressure
        start_dump();
        do_dump(1'b1);

        // Second frame: {row,col,A5}
        do_load(1);
        row = 6'd5; col = 6'd9;
        #1;
        check("read_5_9", 32'(in_pix), 32'h000509A5);

        // In-place write: old value same cycle, new value next cycle
        row = 6'd3; col = 6'd4; out_we = 1'b1; out_pix = 24'h123456;
        #1;
        check("write_same_cycle", 32'(in_pix), 32'(ref_mem[3*64+4]));
        step();
        out_we = 1'b0;
        ref_mem[3*64+4] = 24'h123456;
        #1;
        check("write_visible", 32'(in_pix), 32'h123456);

        // Random in-place writes
        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, 4095);
            v = 24'($urandom);
            row = 6'(a >> 6); col = 6'(a & 63); out_pix = v; out_we = 1'b1;
            step();
            out_we = 1'b0;
            ref_mem[a] = v;
            #1;
            check("rand_write", 32'(in_pix), 32'(v));
        end

        // Dump with m_ready held high: back-to-back raster stream
        start_dump();
        do_dump(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_frame_store.md
# image_frame_store

- Owns the 64x64 RGB frame buffer that the image processing core operates on.
- Responsibilities:
  - accepts a frame as a raster pixel stream;
  - serves the core's row/col reads and write-enabled pixel writes in place;
  - streams the processed frame back out after the core signals completion.
- This is the memory-side responder of the core's `row`/`col`/`in_pix`/`out_we`/`out_pix` interface.

## Interface
Parameters:
- `ADDR_W`, default 6: row/col width; frame is 2^ADDR_W x 2^ADDR_W pixels.
- `PIX_W`, default 24: pixel width (R 23:16, G 15:8, B 7:0).

Ports:
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `s_valid`, input, 1: load-stream pixel valid.
- `s_pix`, input, PIX_W: load-stream pixel, raster order (row-major, col fastest).
- `s_ready`, output, 1: block can accept a load pixel.
- `row`, input, ADDR_W: core row select.
- `col`, input, ADDR_W: core column select.
- `in_pix`, output, PIX_W: buffer contents at [row,col].
- `out_we`, input, 1: core write enable.
- `out_pix`, input, PIX_W: core write data for [row,col].
- `done_in`, input, 1: core final-stage done (filter done).
- `run`, output, 1: high while the core owns the buffer.
- `m_valid`, output, 1: dump-stream pixel valid.
- `m_pix`, output, PIX_W: dump-stream pixel, raster order.
- `m_last`, output, 1: marks the final dump pixel, [63,63].
- `m_ready`, input, 1: downstream accepts the dump pixel.
- `phase`, output, 2: current phase; 0 = LOAD, 1 = RUN, 2 = DUMP.

## Operation
- **Storage:** a single buffer of 2^(2·ADDR_W) words of PIX_W. The address is `{row, col}`. Processing is in place: the core reads and writes the same buffer.
- **Phase state machine:** LOAD -> RUN -> DUMP -> LOAD. There is no other state. Encoding 3 is unreachable; if it is ever entered, the machine goes to LOAD.
- **LOAD:**
  - `s_ready` = 1.
  - On `s_valid & s_ready`: write `s_pix` at the load counter and increment the 12-bit counter.
  - On acceptance of pixel 4095: the counter wraps to 0 and `phase` goes to RUN.
- **RUN:**
  - `run` = 1.
  - `in_pix` = buffer[{row,col}] combinationally, as an asynchronous read with no register.
  - `out_we` = 1 writes `out_pix` to [row,col] at the clock edge. A read of the same address in the same cycle returns the old value.
  - `done_in` sampled high moves `phase` to DUMP on the next edge.
- **DUMP:**
  - The dump counter starts at 0 and `m_pix` is a registered read.
  - First DUMP cycle: prefetch cycle, `m_valid` = 0.
  - From then on `m_valid` = 1 with `m_pix` = pixel[counter].
  - On `m_valid & m_ready`: the counter increments and `m_pix` loads the next pixel at the same edge, allowing back-to-back transfers.
  - After the handshake with `m_last` = 1: `m_valid` drops and `phase` returns to LOAD.
- **Ignored inputs (no effect on buffer or state):**
  - `out_we` outside RUN;
  - `s_valid` outside LOAD;
  - `done_in` outside RUN;
  - `m_ready` while `m_valid` = 0.
- **Backpressure:** while `m_valid` = 1 and `m_ready` = 0, `m_pix` and `m_last` stay stable.
- **Buffer contents:** never cleared. They survive reset and phase changes.

## Timing
- **Reset values** (during the `rst` cycle and after it):
  - `phase` = 0, `run` = 0, `m_valid` = 0, `m_last` = 0, `m_pix` = 0.
  - Both counters = 0.
  - `s_ready` = 0 while `rst` = 1, and 1 from the first cycle after `rst` deasserts.
- **Reset mid-operation:** reset in any phase aborts at the next edge, returns to LOAD with the counters at 0, and leaves the buffer untouched. A partial load restarts at pixel 0.
- **Load:** completes in exactly 4096 handshakes. `run` rises the cycle after the last accepted pixel.
- **RUN to DUMP:** `done_in` high at edge N gives `run` = 0 from N+1. `m_valid` = 1 from N+2.
- **Dump:** completes in 4096 handshakes plus 1 prefetch cycle. `s_ready` rises the cycle after the final handshake.
- **`in_pix` latency:** 0 cycles from `row`/`col`. The core registers `row`/`col` and samples `in_pix` in the following combinational state.
- **Write visibility:** a write at edge N is visible on `in_pix` from N+1.

## Test plan
1. **Reset mid-load:** load 100 pixels, then pulse `rst` -> `s_ready` = 0 during `rst` and back to 1 afterwards, `phase` = 0. Load a full frame with pixel value = index -> `run` = 1 exactly after the 4096th handshake.
2. **Core read:** full load with pix = {row,col,8'hA5} -> in RUN, `row` = 5, `col` = 9 gives `in_pix` = 24'h0509A5 in the same cycle.
3. **Core write and read-back:** `out_we` = 1, [3,4] <= 24'h123456 -> `in_pix` at [3,4] = 24'h123456 next cycle. The same write in LOAD or DUMP leaves the buffer unchanged.
4. **Done and dump:** `done_in` pulse -> `m_valid` rises 2 edges later. With `m_ready` = 1 constantly: 4096 consecutive pixels in raster order, including the in-RUN write above, and `m_last` only on the final one.
5. **Dump backpressure:** toggle `m_ready` randomly -> no drops or duplicates, `m_pix` stable while stalled. The final handshake returns `phase` to 0.
6. **Stray inputs:** `s_valid` held 1 during RUN/DUMP and `done_in` during LOAD -> no writes, no phase change.
